proj_fm_buf_ctrl: RTL and testbench

//   Parametrised N-way feature-map buffer. Packs a serial stream of DATA_BITS words into BUFFER_COUNT

---
 rtl/proj_fm_buf_ctrl.sv | 175 +++++++++++++++++
 tb/tb_proj_fm_buf_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_fm_buf_ctrl.sv
// proj_fm_buf_ctrl: N-way rotating feature-map buffer.
// A serial stream of DATA_BITS words is packed into BUFFER_COUNT buffers of
// BUF_WORDS = RAMS*ENTRIES*OFFSET words. Each full buffer is returned as
// CHUNK_SIZE-word chunks through a single registered output stage.
// Optional feature: define PROJ_FM_STATS_EN to add out_drop_cnt, a saturating
// count of cycles where a write was offered but the buffer was full.
module proj_fm_buf_ctrl #(
    parameter int BUFFER_COUNT = 2,
    parameter int RAMS         = 2,
    parameter int ENTRIES      = 2,
    parameter int OFFSET       = 1,
    parameter int CHUNK_SIZE   = 2,
    parameter int DATA_BITS    = 8
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic                             in_wvalid,
    output logic                             out_wready,
    input  logic [DATA_BITS-1:0]             in_wdata,
    output logic                             out_rvalid,
    input  logic                             in_rready,
    output logic [CHUNK_SIZE*DATA_BITS-1:0]  out_rdata,
    output logic                             out_rlast,
    output logic [$clog2(BUFFER_COUNT+1)-1:0] out_filled
`ifdef PROJ_FM_STATS_EN
    ,
    output logic [15:0]                      out_drop_cnt
`endif
);

    localparam int BUF_WORDS = RAMS * ENTRIES * OFFSET;
    localparam int NCHUNK    = BUF_WORDS / CHUNK_SIZE;
    localparam int IDX_W     = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1;
    localparam int ADDR_W    = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
    localparam int CHK_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int FILL_W    = $clog2(BUFFER_COUNT + 1);
    localparam int CHUNK_W   = CHUNK_SIZE * DATA_BITS;

    // Reject configurations that cannot be split into whole chunks.
    if (BUF_WORDS % CHUNK_SIZE != 0) begin : g_bad_chunk
        $error("proj_fm_buf_ctrl: BUF_WORDS must be a multiple of CHUNK_SIZE");
    end
    if (BUFFER_COUNT < 2) begin : g_bad_count
        $error("proj_fm_buf_ctrl: BUFFER_COUNT must be at least 2");
    end

    logic [DATA_BITS-1:0] mem_q [BUFFER_COUNT][BUF_WORDS];

    logic [IDX_W-1:0]  wr_idx_q,   wr_idx_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [IDX_W-1:0]  rd_idx_q,   rd_idx_d;
    logic [CHK_W-1:0]  rd_chunk_q, rd_chunk_d;
    logic [FILL_W-1:0] filled_q,   filled_d;
    logic [CHUNK_W-1:0] rdata_q,   rdata_d;
    logic              rvalid_q,   rvalid_d;
    logic              rlast_q,    rlast_d;

    logic               wr_fire;
    logic               wr_done;
    logic               load;
    logic               rd_done;
    logic [ADDR_W-1:0]  rd_base;
    logic [CHUNK_W-1:0] chunk_data;

    // Handshake qualifiers; write readiness depends on stored state only.
    assign out_wready = (filled_q < FILL_W'(BUFFER_COUNT));
    assign wr_fire    = in_wvalid && out_wready;
    assign wr_done    = wr_fire && (wr_addr_q == ADDR_W'(BUF_WORDS - 1));
    assign load       = (filled_q != '0) && (!rvalid_q || in_rready);
    assign rd_done    = load && (rd_chunk_q == CHK_W'(NCHUNK - 1));

    // Gather chunk rd_chunk of buffer rd_idx, lowest-addressed word in the LSBs.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        chunk_data = '0;
        rd_base    = ADDR_W'(rd_chunk_q) * ADDR_W'(CHUNK_SIZE);
        for (int k = 0; k < CHUNK_SIZE; k++) begin
            chunk_data[k*DATA_BITS +: DATA_BITS] = mem_q[rd_idx_q][rd_base + ADDR_W'(k)];
        end
    end

    // Next-state for the write pointer, read pointer, fill count and output stage.
    always_comb begin
        wr_idx_d   = wr_idx_q;
        wr_addr_d  = wr_addr_q;
        rd_idx_d   = rd_idx_q;
        rd_chunk_d = rd_chunk_q;
        filled_d   = filled_q;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;

        if (wr_fire) begin
            if (wr_done) begin
                wr_addr_d = '0;
                wr_idx_d  = (wr_idx_q == IDX_W'(BUFFER_COUNT - 1)) ? '0 : wr_idx_q + IDX_W'(1);
            end else begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
        end

        if (load) begin
            rdata_d  = chunk_data;
            rvalid_d = 1'b1;
            rlast_d  = rd_done;
            if (rd_done) begin
                rd_chunk_d = '0;
                rd_idx_d   = (rd_idx_q == IDX_W'(BUFFER_COUNT - 1)) ? '0 : rd_idx_q + IDX_W'(1);
            end else begin
                rd_chunk_d = rd_chunk_q + CHK_W'(1);
            end
        end else if (in_rready) begin
            rvalid_d = 1'b0;
        end

        // A buffer completing and another being released on one edge cancel out.
        case ({wr_done, rd_done})
            2'b10:   filled_d = filled_q + FILL_W'(1);
            2'b01:   filled_d = filled_q - FILL_W'(1);
            default: filled_d = filled_q;
        endcase
    end

    // Control and output-stage registers.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            wr_idx_q   <= '0;
            wr_addr_q  <= '0;
            rd_idx_q   <= '0;
            rd_chunk_q <= '0;
            filled_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            wr_addr_q  <= wr_addr_d;
            rd_idx_q   <= rd_idx_d;
            rd_chunk_q <= rd_chunk_d;
            filled_q   <= filled_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
        end
    end

    // Buffer storage write port.
    // NOTE: the storage array has no reset; words are only read after being rewritten.
    always_ff @(posedge in_clk) begin
        if (wr_fire) begin
            mem_q[wr_idx_q][wr_addr_q] <= in_wdata;
        end
    end

    assign out_rdata  = rdata_q;
    assign out_rvalid = rvalid_q;
    assign out_rlast  = rlast_q;
    assign out_filled = filled_q;

`ifdef PROJ_FM_STATS_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of cycles where a write was offered while full.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            drop_cnt_q <= 16'd0;
        end else if (in_wvalid && !out_wready && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign out_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_proj_fm_buf_ctrl.sv
// Directed bench for proj_fm_buf_ctrl: reset, basic flow, backpressure,
// simultaneous complete/release, index wrap with BUFFER_COUNT=3, and the
// optional drop counter when PROJ_FM_STATS_EN is defined.
module tb_proj_fm_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    // Default-parameter instance.
    logic        wvalid, wready, rvalid, rready, rlast;
    logic [7:0]  wdata;
    logic [15:0] rdata;
    logic [1:0]  filled;

    // Wrap instance: BUFFER_COUNT=3, CHUNK_SIZE=4.
    logic        wvalid2, wready2, rvalid2, rready2, rlast2;
    logic [7:0]  wdata2;
    logic [31:0] rdata2;
    logic [2:0]  filled2;

`ifdef PROJ_FM_STATS_EN
    logic [15:0] drop_cnt, drop_cnt2;
`endif

    always #5 clk = ~clk;

    proj_fm_buf_ctrl dut (
        .in_clk     (clk),
        .in_rst     (rst),
        .in_wvalid  (wvalid),
        .out_wready (wready),
        .in_wdata   (wdata),
        .out_rvalid (rvalid),
        .in_rready  (rready),
        .out_rdata  (rdata),
        .out_rlast  (rlast),
        .out_filled (filled)
`ifdef PROJ_FM_STATS_EN
        ,
        .out_drop_cnt (drop_cnt)
`endif
    );

    proj_fm_buf_ctrl #(.BUFFER_COUNT(3), .CHUNK_SIZE(4)) dut_w (
        .in_clk     (clk),
        .in_rst     (rst),
        .in_wvalid  (wvalid2),
        .out_wready (wready2),
        .in_wdata   (wdata2),
        .out_rvalid (rvalid2),
        .in_rready  (rready2),
        .out_rdata  (rdata2),
        .out_rlast  (rlast2),
        .out_filled (filled2)
`ifdef PROJ_FM_STATS_EN
        ,
        .out_drop_cnt (drop_cnt2)
`endif
    );

    // Offer one word to dut from a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [7:0] d);
        int t = 0;
        wvalid = 1'b1;
        wdata  = d;
        while (!wready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!wready) begin
            checks++; errors++;
            $display("FAIL push_timeout word=%h wready=%b expected 1", d, wready);
        end
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic push_w(input logic [7:0] d);
        int t = 0;
        wvalid2 = 1'b1;
        wdata2  = d;
        while (!wready2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!wready2) begin
            checks++; errors++;
            $display("FAIL push_w_timeout word=%h wready=%b expected 1", d, wready2);
        end
        @(negedge clk);
        wvalid2 = 1'b0;
    endtask

    // With rready high, wait for a chunk, check it, and step past its consumption.
    task automatic pop(input logic [15:0] exp_d, input logic exp_l, input string name);
        int t = 0;
        while (!rvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s_rvalid got %b expected 1", name, rvalid);
        end
        checks++;
        if (rdata !== exp_d) begin
            errors++;
            $display("FAIL %s_rdata got %h expected %h", name, rdata, exp_d);
        end
        checks++;
        if (rlast !== exp_l) begin
            errors++;
            $display("FAIL %s_rlast got %b expected %b", name, rlast, exp_l);
        end
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({wready, rvalid, rlast, filled, rdata} !== {1'b1, 1'b0, 1'b0, 2'd0, 16'h0000}) begin
            errors++;
            $display("FAIL %s got wready=%b rvalid=%b rlast=%b filled=%0d rdata=%h expected 1 0 0 0 0000",
                     name, wready, rvalid, rlast, filled, rdata);
        end
    endtask

    task automatic test_reset();
        rready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid_buffer");
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset_released");
        rready = 1'b1;
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        pop(16'hA1A0, 1'b0, "reset_chunk0");
        pop(16'hA3A2, 1'b1, "reset_chunk1");
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain rvalid got %b expected 0", rvalid);
        end
    endtask

    task automatic test_basic();
        rready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(i));
        // Just after the 4th accept edge: buffer counted, output not yet loaded.
        checks++;
        if (rvalid !== 1'b0 || filled !== 2'd1) begin
            errors++;
            $display("FAIL basic_after_accept rvalid=%b filled=%0d expected 0 1", rvalid, filled);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h0100 || rlast !== 1'b0 || filled !== 2'd1) begin
            errors++;
            $display("FAIL basic_chunk0 rvalid=%b rdata=%h rlast=%b filled=%0d expected 1 0100 0 1",
                     rvalid, rdata, rlast, filled);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 16'h0302 || rlast !== 1'b1 || filled !== 2'd0) begin
            errors++;
            $display("FAIL basic_chunk1 rvalid=%b rdata=%h rlast=%b filled=%0d expected 1 0302 1 0",
                     rvalid, rdata, rlast, filled);
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain rvalid got %b expected 0", rvalid);
        end
    endtask

    task automatic test_backpressure();
        rready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(i));
        checks++;
        if (wready !== 1'b0 || filled !== 2'd2) begin
            errors++;
            $display("FAIL bp_full wready=%b filled=%0d expected 0 2", wready, filled);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== 16'h0100 || rlast !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold rvalid=%b rdata=%h rlast=%b expected 1 0100 0", rvalid, rdata, rlast);
            end
            @(negedge clk);
        end
        rready = 1'b1;
        fork
            begin
                for (int i = 8; i < 12; i++) push(8'(i));
            end
            begin
                pop(16'h0100, 1'b0, "bp_c0");
                pop(16'h0302, 1'b1, "bp_c1");
                pop(16'h0504, 1'b0, "bp_c2");
                pop(16'h0706, 1'b1, "bp_c3");
                pop(16'h0908, 1'b0, "bp_c4");
                pop(16'h0B0A, 1'b1, "bp_c5");
            end
        join
        @(negedge clk);
        checks++;
        if (filled !== 2'd0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain filled=%0d rvalid=%b expected 0 0", filled, rvalid);
        end
    endtask

    task automatic test_simultaneous();
        rready = 1'b0;
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        push(8'h20); push(8'h21); push(8'h22);
        checks++;
        if (filled !== 2'd1 || rdata !== 16'h1110 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL sim_setup filled=%0d rdata=%h rvalid=%b expected 1 1110 1", filled, rdata, rvalid);
        end
        // Final word of buffer B and the last chunk of buffer A share one edge.
        wvalid = 1'b1;
        wdata  = 8'h23;
        rready = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if (filled !== 2'd1 || rdata !== 16'h1312 || rlast !== 1'b1 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL sim_edge filled=%0d rdata=%h rlast=%b rvalid=%b expected 1 1312 1 1",
                     filled, rdata, rlast, rvalid);
        end
        @(negedge clk);
        pop(16'h2120, 1'b0, "sim_b0");
        pop(16'h2322, 1'b1, "sim_b1");
        checks++;
        if (filled !== 2'd0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL sim_drain filled=%0d rvalid=%b expected 0 0", filled, rvalid);
        end
    endtask

    task automatic test_wrap();
        int got = 0;
        logic [31:0] exp_chunk;
        fork
            begin
                for (int i = 0; i < 32; i++) push_w(8'(i));
            end
            begin
                for (int cyc = 0; cyc < 3000 && got < 8; cyc++) begin
                    rready2 = 1'($urandom_range(0, 1));
                    if (rvalid2 && rready2) begin
                        exp_chunk = {8'(4*got+3), 8'(4*got+2), 8'(4*got+1), 8'(4*got)};
                        checks++;
                        if (rdata2 !== exp_chunk || rlast2 !== 1'b1) begin
                            errors++;
                            $display("FAIL wrap_chunk%0d rdata=%h rlast=%b expected %h 1",
                                     got, rdata2, rlast2, exp_chunk);
                        end
                        got++;
                    end
                    @(negedge clk);
                end
                rready2 = 1'b0;
            end
        join
        checks++;
        if (got != 8 || filled2 !== 3'd0) begin
            errors++;
            $display("FAIL wrap_count chunks=%0d filled=%0d expected 8 0", got, filled2);
        end
    endtask

`ifdef PROJ_FM_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset got %0d expected 0", drop_cnt);
        end
        rready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(i));
        wvalid = 1'b1;
        wdata  = 8'hEE;
        repeat (10) @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if (drop_cnt !== 16'd10) begin
            errors++;
            $display("FAIL stats_drops got %0d expected 10", drop_cnt);
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        wvalid  = 1'b0;
        wdata   = '0;
        rready  = 1'b0;
        wvalid2 = 1'b0;
        wdata2  = '0;
        rready2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_basic();
        @(negedge clk);
        test_backpressure();
        @(negedge clk);
        test_simultaneous();
        @(negedge clk);
        test_wrap();
`ifdef PROJ_FM_STATS_EN
        @(negedge clk);
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
